// File: rtl/als_pkg.sv
// Shared types and sizing helpers for the ambient-light-sensor SPI sampler.
package als_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAKE,
        QUIET,
        FRAME,
        WAIT
    } als_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/als_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV clocks while enabled, idling high.
module als_sclk_gen
    import als_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic restart,
    output logic sclk,
    output logic rise_pulse,
    output logic half_done
);

    localparam int DIV_W = cnt_width(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // half_done marks the clk whose edge ends the current half-period.
    assign half_done  = en && (div_cnt == DIV_LAST);
    assign rise_pulse = half_done && !sclk;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (!en || restart) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (half_done) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/als_spi_sampler.sv
// SPI master for serial-output light-sensor ADCs: discards a wake-up frame, then
// paces conversion frames and reports raw and boxcar-averaged samples.
module als_spi_sampler
    import als_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int FRAME_BITS    = 16,
    parameter int DATA_MSB      = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int WAKE_BITS     = 13,
    parameter int QUIET_CYCLES  = 6,
    parameter int PERIOD_CYCLES = 0,
    parameter int AVG_LOG2      = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  run_en,
    input  logic                  sdo,
    output logic                  cs_n,
    output logic                  sclk,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  sample_valid,
    output logic [DATA_WIDTH-1:0] avg,
    output logic                  avg_valid,
    output logic                  busy
);

    localparam int BIT_W  = cnt_width(max2(WAKE_BITS, FRAME_BITS));
    localparam int TMR_W  = cnt_width(max2(QUIET_CYCLES, PERIOD_CYCLES));
    localparam int AVG_N  = 1 << AVG_LOG2;
    localparam int SCNT_W = cnt_width(AVG_N - 1);
    localparam int ACC_W  = DATA_WIDTH + AVG_LOG2;
    localparam int SR_W   = DATA_MSB + 1;

    als_state_e state, next_state;

    logic [BIT_W-1:0]      bit_cnt;
    logic [TMR_W-1:0]      timer;
    logic [SR_W-1:0]       shift_reg;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_sum;
    logic [SCNT_W-1:0]     sample_cnt;
    logic [DATA_WIDTH-1:0] field;
    logic                  after_wake;
    logic                  active;
    logic                  frame_end;
    logic                  rise_pulse;
    logic                  half_done;

    assign active    = (state == WAKE) || (state == FRAME);
    assign frame_end = half_done &&
                       (bit_cnt == ((state == WAKE) ? BIT_W'(WAKE_BITS) : BIT_W'(FRAME_BITS)));
    assign field     = shift_reg[DATA_MSB -: DATA_WIDTH];
    assign acc_sum   = acc + ACC_W'(field);
    assign busy      = (state != IDLE);

    // A restart on the closing half-period keeps sclk parked high into QUIET.
    als_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .resetn    (resetn),
        .en        (active),
        .restart   (frame_end || !run_en),
        .sclk      (sclk),
        .rise_pulse(rise_pulse),
        .half_done (half_done)
    );

    always_comb begin
        next_state = state;
        if (!run_en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:        next_state = WAKE;
                WAKE, FRAME: if (frame_end) next_state = QUIET;
                QUIET: begin
                    // The wake-up frame is followed straight by data, never by WAIT.
                    if (timer == TMR_W'(QUIET_CYCLES - 1))
                        next_state = ((PERIOD_CYCLES > 0) && !after_wake) ? WAIT : FRAME;
                end
                WAIT:        if (timer == TMR_W'(PERIOD_CYCLES - 1)) next_state = FRAME;
                default:     next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cs_n       <= 1'b1;
            timer      <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            after_wake <= 1'b0;
        end else begin
            state <= next_state;
            cs_n  <= !((next_state == WAKE) || (next_state == FRAME));

            if ((next_state != state) || !(state inside {QUIET, WAIT}))
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (!run_en || frame_end || !active)
                bit_cnt <= '0;
            else if (rise_pulse)
                bit_cnt <= bit_cnt + 1'b1;

            if (active && rise_pulse)
                shift_reg <= {shift_reg[SR_W-2:0], sdo};

            if (state == WAKE)
                after_wake <= 1'b1;
            else if ((state == FRAME) || (state == IDLE))
                after_wake <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            avg          <= '0;
            avg_valid    <= 1'b0;
            acc          <= '0;
            sample_cnt   <= '0;
        end else begin
            sample_valid <= 1'b0;
            avg_valid    <= 1'b0;
            if (!run_en) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else if ((state == FRAME) && frame_end) begin
                sample       <= field;
                sample_valid <= 1'b1;
                if (sample_cnt == SCNT_W'(AVG_N - 1)) begin
                    avg        <= DATA_WIDTH'(acc_sum >> AVG_LOG2);
                    avg_valid  <= 1'b1;
                    acc        <= '0;
                    sample_cnt <= '0;
                end else begin
                    acc        <= acc_sum;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_als_spi_sampler.sv
// Scoreboard bench for als_spi_sampler: default, slow/paced and unaveraged wide-field builds.
module tb_als_spi_sampler;

    typedef struct {
        logic [11:0] sample;
        logic        avg_valid;
        logic [11:0] avg;
    } exp_t;

    logic clk;
    logic resetn;

    logic       run_en_a, sdo_a, cs_n_a, sclk_a, sample_valid_a, avg_valid_a, busy_a;
    logic [7:0] sample_a, avg_a;

    logic       run_en_b, sdo_b, cs_n_b, sclk_b, sample_valid_b, avg_valid_b, busy_b;
    logic [7:0] sample_b, avg_b;

    logic        run_en_c, sdo_c, cs_n_c, sclk_c, sample_valid_c, avg_valid_c, busy_c;
    logic [11:0] sample_c, avg_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t        exp_a[$];
    exp_t        exp_c[$];
    exp_t        e_a, e_c;
    logic [15:0] word_q[$];
    logic [15:0] cur_word;
    int          bit_idx = 16;

    int   rises_a[$];
    int   gaps_a[$];
    int   falls_a = 0, cur_rises_a = 0, high_a = 0, samples_a = 0;
    logic in_win_a = 0, seen_a = 0, prev_cs_a = 1, prev_sclk_a = 1;

    int   fall_b[$], rise_b[$], srise_b[$];
    int   avgv_b = 0;
    logic prev_cs_b = 1, prev_sclk_b = 1;

    int samples_c = 0;

    int base_r, base_g, base_f, s0, d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    als_spi_sampler u_dut_a (
        .clk(clk), .resetn(resetn), .run_en(run_en_a), .sdo(sdo_a),
        .cs_n(cs_n_a), .sclk(sclk_a), .sample(sample_a), .sample_valid(sample_valid_a),
        .avg(avg_a), .avg_valid(avg_valid_a), .busy(busy_a)
    );

    als_spi_sampler #(.CLK_DIV(4), .PERIOD_CYCLES(100)) u_dut_b (
        .clk(clk), .resetn(resetn), .run_en(run_en_b), .sdo(sdo_b),
        .cs_n(cs_n_b), .sclk(sclk_b), .sample(sample_b), .sample_valid(sample_valid_b),
        .avg(avg_b), .avg_valid(avg_valid_b), .busy(busy_b)
    );

    als_spi_sampler #(.AVG_LOG2(0), .DATA_WIDTH(12), .DATA_MSB(14)) u_dut_c (
        .clk(clk), .resetn(resetn), .run_en(run_en_c), .sdo(sdo_c),
        .cs_n(cs_n_c), .sclk(sclk_c), .sample(sample_c), .sample_valid(sample_valid_c),
        .avg(avg_c), .avg_valid(avg_valid_c), .busy(busy_c)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkNear(input string name, input int actual, input int expected, input int tol);
        checks++;
        if (actual < expected - tol || actual > expected + tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d +/- %0d", name, actual, expected, tol);
        end
    endtask

    // Queue a sensor word for the next cs_n frame; data frames also queue their expected result.
    task automatic applyStimulus(input logic [15:0] word, input bit expect_sample,
                                 input logic [11:0] smp, input logic av, input logic [11:0] avgv);
        exp_t e;
        word_q.push_back(word);
        if (expect_sample) begin
            e.sample = smp; e.avg_valid = av; e.avg = avgv;
            exp_a.push_back(e);
        end
    endtask

    task automatic waitCount(input int which, input int target, input string name);
        int n;
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            n = (which == 0) ? samples_a : (which == 1) ? samples_c : fall_b.size();
            if (n >= target) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("[TB] FAIL %s: timed out, count %0d needed %0d", name, n, target);
    endtask

    task automatic waitRise(input int fall_target, input int rise_target, input string name);
        for (int i = 0; i < 5000; i++) begin
            if (falls_a >= fall_target && cur_rises_a >= rise_target) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("[TB] FAIL %s: timed out, falls %0d rises %0d", name, falls_a, cur_rises_a);
    endtask

    function automatic int riseAt(input int i);
        return (i < rises_a.size()) ? rises_a[i] : -1;
    endfunction

    function automatic int gapAt(input int i);
        return (i < gaps_a.size()) ? gaps_a[i] : -1;
    endfunction

    function automatic int stampB(input int which, input int i);
        if (which == 0) return (i < fall_b.size()) ? fall_b[i] : -1000;
        if (which == 1) return (i < rise_b.size()) ? rise_b[i] : -1000;
        return (i < srise_b.size()) ? srise_b[i] : -1000;
    endfunction

    task automatic checkResetA(input string tag, input logic [7:0] smp, input logic [7:0] av);
        checkOutput({tag, "_cs_n"}, cs_n_a, 1);
        checkOutput({tag, "_sclk"}, sclk_a, 1);
        checkOutput({tag, "_sample"}, sample_a, smp);
        checkOutput({tag, "_avg"}, avg_a, av);
        checkOutput({tag, "_sample_valid"}, sample_valid_a, 0);
        checkOutput({tag, "_avg_valid"}, avg_valid_a, 0);
        checkOutput({tag, "_busy"}, busy_a, 0);
    endtask

    initial begin
        resetn = 0; run_en_a = 0; run_en_b = 0; run_en_c = 0;
        sdo_a = 0; sdo_b = 0; sdo_c = 1;

        fork
            // Sensor model for instance A: new word per cs_n fall, MSB launched on each sclk fall.
            forever begin
                @(negedge cs_n_a);
                cur_word = (word_q.size() > 0) ? word_q.pop_front() : 16'h0000;
                bit_idx = 0;
            end
            forever begin
                @(negedge sclk_a);
                if (!cs_n_a && bit_idx < 16) begin
                    sdo_a = cur_word[15 - bit_idx];
                    bit_idx++;
                end
            end
            // Monitors and scoreboards, sampled on the falling clk edge.
            forever begin
                @(negedge clk);
                cyc++;
                if (!resetn) begin
                    in_win_a = 0; seen_a = 0; cur_rises_a = 0;
                end else begin
                    if (prev_cs_a && !cs_n_a) begin
                        falls_a++; in_win_a = 1; cur_rises_a = 0;
                        if (seen_a) gaps_a.push_back(high_a);
                    end
                    if (!prev_cs_a && cs_n_a && in_win_a) begin
                        rises_a.push_back(cur_rises_a);
                        in_win_a = 0; seen_a = 1; high_a = 0;
                    end
                    if (!cs_n_a && sclk_a && !prev_sclk_a) cur_rises_a++;
                    if (cs_n_a) high_a++;
                    if (!busy_a) seen_a = 0;
                end
                if (sample_valid_a) begin
                    if (exp_a.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL a_unexpected_sample: got sample %0h, none expected", sample_a);
                    end else begin
                        e_a = exp_a.pop_front();
                        checkOutput("a_sample", {24'h0, sample_a}, {20'h0, e_a.sample});
                        checkOutput("a_avg_valid", avg_valid_a, e_a.avg_valid);
                        if (e_a.avg_valid) checkOutput("a_avg", {24'h0, avg_a}, {20'h0, e_a.avg});
                    end
                    samples_a++;
                end else if (avg_valid_a) begin
                    checkOutput("a_avg_valid_needs_sample", sample_valid_a, 1);
                end

                if (prev_cs_b && !cs_n_b) fall_b.push_back(cyc);
                if (!prev_cs_b && cs_n_b) rise_b.push_back(cyc);
                if (!cs_n_b && sclk_b && !prev_sclk_b) srise_b.push_back(cyc);
                if (sample_valid_b) checkOutput("b_sample", {24'h0, sample_b}, 0);
                if (avg_valid_b) avgv_b++;

                if (sample_valid_c) begin
                    if (exp_c.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL c_unexpected_sample: got sample %0h, none expected", sample_c);
                    end else begin
                        e_c = exp_c.pop_front();
                        checkOutput("c_sample", {20'h0, sample_c}, {20'h0, e_c.sample});
                        checkOutput("c_avg_valid", avg_valid_c, e_c.avg_valid);
                        checkOutput("c_avg", {20'h0, avg_c}, {20'h0, e_c.avg});
                    end
                    samples_c++;
                end else if (avg_valid_c) begin
                    checkOutput("c_avg_valid_needs_sample", sample_valid_c, 1);
                end

                prev_cs_a = cs_n_a; prev_sclk_a = sclk_a;
                prev_cs_b = cs_n_b; prev_sclk_b = sclk_b;
            end
        join_none

        repeat (3) @(negedge clk);
        checkResetA("reset", 8'h00, 8'h00);
        resetn = 1;
        @(negedge clk);

        // Wake length, first sample and quiet gap.
        base_r = rises_a.size(); base_g = gaps_a.size(); s0 = samples_a;
        applyStimulus(16'hFFFF, 0, 0, 0, 0);
        applyStimulus(16'h0AB0, 1, 12'h055, 0, 0);
        applyStimulus(16'h0AB0, 1, 12'h055, 0, 0);
        run_en_a = 1;
        waitCount(0, s0 + 2, "t1_samples");
        run_en_a = 0;
        repeat (3) @(negedge clk);
        word_q.delete();
        checkOutput("t1_wake_rises", riseAt(base_r), 13);
        checkOutput("t1_frame_rises", riseAt(base_r + 1), 16);
        checkOutput("t1_gap_after_wake", gapAt(base_g), 6);
        checkOutput("t1_gap_between_frames", gapAt(base_g + 1), 6);

        // Boxcar of four: 10,20,30,41 -> 28, then three samples with no average.
        s0 = samples_a;
        applyStimulus(16'h1234, 0, 0, 0, 0);
        applyStimulus(16'h0200, 1, 12'h010, 0, 0);
        applyStimulus(16'h0400, 1, 12'h020, 0, 0);
        applyStimulus(16'h0600, 1, 12'h030, 0, 0);
        applyStimulus(16'h0820, 1, 12'h041, 1, 12'h028);
        applyStimulus(16'h0AB0, 1, 12'h055, 0, 0);
        applyStimulus(16'h0AB0, 1, 12'h055, 0, 0);
        applyStimulus(16'h0AB0, 1, 12'h055, 0, 0);
        run_en_a = 1;
        waitCount(0, s0 + 7, "t2_samples");
        run_en_a = 0;
        repeat (3) @(negedge clk);
        word_q.delete();
        checkOutput("t2_avg_holds", {24'h0, avg_a}, 32'h28);

        // Drop run_en after 7 data-frame rising edges.
        base_f = falls_a;
        applyStimulus(16'hFFFF, 0, 0, 0, 0);
        applyStimulus(16'h0F0F, 0, 0, 0, 0);
        run_en_a = 1;
        waitRise(base_f + 2, 7, "t4_seven_rises");
        run_en_a = 0;
        @(posedge clk);
        #1;
        checkResetA("t4_drop", 8'h55, 8'h28);
        repeat (3) @(negedge clk);
        word_q.delete();
        base_r = rises_a.size(); s0 = samples_a;
        applyStimulus(16'hFFFF, 0, 0, 0, 0);
        applyStimulus(16'h0AB0, 1, 12'h055, 0, 0);
        run_en_a = 1;
        waitCount(0, s0 + 1, "t4_resume");
        run_en_a = 0;
        repeat (3) @(negedge clk);
        word_q.delete();
        checkOutput("t4_rewake_rises", riseAt(base_r), 13);
        checkOutput("t4_refame_rises", riseAt(base_r + 1), 16);

        // Asynchronous reset in the middle of a data frame.
        base_f = falls_a;
        applyStimulus(16'hFFFF, 0, 0, 0, 0);
        applyStimulus(16'h0F0F, 0, 0, 0, 0);
        run_en_a = 1;
        waitRise(base_f + 2, 4, "t5_mid_frame");
        #1 resetn = 0;
        #1;
        checkResetA("t5_async", 8'h00, 8'h00);
        @(negedge clk);
        word_q.delete();
        base_r = rises_a.size(); s0 = samples_a;
        applyStimulus(16'hFFFF, 0, 0, 0, 0);
        applyStimulus(16'h0AB0, 1, 12'h055, 0, 0);
        @(negedge clk);
        resetn = 1;
        waitCount(0, s0 + 1, "t5_restart");
        run_en_a = 0;
        repeat (3) @(negedge clk);
        checkOutput("t5_wake_rises", riseAt(base_r), 13);

        // CLK_DIV=4, PERIOD_CYCLES=100 pacing.
        run_en_b = 1;
        waitCount(2, 3, "t3_frames");
        run_en_b = 0;
        repeat (3) @(negedge clk);
        checkOutput("t3_wake_low_clks", stampB(1, 0) - stampB(0, 0), 108);
        checkOutput("t3_wake_to_frame", stampB(0, 1) - stampB(0, 0), 114);
        checkOutput("t3_frame_low_clks", stampB(1, 1) - stampB(0, 1), 132);
        checkOutput("t3_first_rise_delay", stampB(2, 13) - stampB(0, 1), 8);
        checkOutput("t3_sclk_period", stampB(2, 14) - stampB(2, 13), 8);
        d = stampB(0, 2) - stampB(0, 1);
        $display("[TB] frame start to frame start %0d clks, nominal 238 (16*8+4+6+100), +/-1 for registered cs_n", d);
        checkNear("t3_frame_to_frame", d, 238, 1);
        checkOutput("t3_no_avg_valid", avgv_b, 0);
        checkOutput("t3_avg_idle", {24'h0, avg_b}, 0);
        checkOutput("t3_busy_dropped", busy_b, 0);

        // Unaveraged 12-bit field from an all-ones stream.
        s0 = samples_c;
        for (int i = 0; i < 3; i++) begin
            e_c.sample = 12'hFFF; e_c.avg_valid = 1'b1; e_c.avg = 12'hFFF;
            exp_c.push_back(e_c);
        end
        run_en_c = 1;
        waitCount(1, s0 + 3, "t6_samples");
        run_en_c = 0;
        repeat (4) @(negedge clk);
        checkOutput("t6_busy_dropped", busy_c, 0);

        checkOutput("a_queue_drained", exp_a.size(), 0);
        checkOutput("c_queue_drained", exp_c.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
